// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU.
//   Opcode constants (5-bit), operation-class decode and FSM state encoding.
//   Optional feature: define ALU_SEQ_DIV_EN to decode DIV/DIVU/REM/REMU as
//   iterative operations; otherwise they decode as illegal.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   typedef enum logic [1:0] {
      CLS_SINGLE,
      CLS_MUL,
      CLS_DIV,
      CLS_ILLEGAL
   } op_class_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_e;

   function automatic op_class_e op_class(input logic [4:0] op);
      op_class_e c;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU:    c = CLS_SINGLE;
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:       c = CLS_MUL;
`ifdef ALU_SEQ_DIV_EN
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:           c = CLS_DIV;
`endif
         default:                                    c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if -- request/result handshake bundle of the sequential ALU.
//   Request : in_valid, in_ready, in_op, in_a, in_b
//   Result  : out_valid, out_ready, out_result, out_illegal
//   master = requester/consumer side, slave = the ALU.
interface alu_seq_unit_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OP_W = 5
) ();
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_illegal;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_illegal
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_illegal
   );
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter -- radix-2 iterative engine: shift-add multiply and (when
//   ALU_SEQ_DIV_EN is defined) restoring divide, sharing one XLEN-bit adder,
//   the hi/lo working registers and the iteration counter.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operands (first iteration is performed on this edge)
//   op, a, b   : opcode and raw operands, sampled on start
//   done       : all XLEN iterations complete; result is valid
//   result     : sign-corrected product half / quotient / remainder
module alu_seq_iter
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int unsigned  CW   = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN);

   logic [4:0]        op_q;
   logic [XLEN-1:0]   hi, lo, mcand;
   logic [XLEN-1:0]   hi_nxt, lo_nxt;
   logic [XLEN-1:0]   cur_hi, cur_lo, cur_m;
   logic [XLEN-1:0]   add_a, add_b, sum;
   logic              add_c, carry;
   logic [CW-1:0]     cnt;
   logic              run, neg_p;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] prod;
`ifdef ALU_SEQ_DIV_EN
   logic              div_q, cur_div, ge, neg_r, bzero;
   logic [XLEN-1:0]   a_q;
`endif

   // Signed operations run on magnitudes; the sign is re-applied at the output.
   always_comb begin
      a_neg = a[XLEN-1] & ((op == OP_MULH) || (op == OP_MULHSU) ||
                           (op == OP_DIV)  || (op == OP_REM));
      b_neg = b[XLEN-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // On start the step works from the fresh operands so the load edge
   // also counts as iteration 1.
   always_comb begin
      cur_hi = start ? '0    : hi;
      cur_lo = start ? a_mag : lo;
      cur_m  = start ? b_mag : mcand;
   end

`ifdef ALU_SEQ_DIV_EN
   assign cur_div = start ? (op_class(op) == CLS_DIV) : div_q;
`endif

   always_comb begin
      add_a = cur_hi;
      add_b = cur_lo[0] ? cur_m : '0;
      add_c = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      ge = 1'b0;
      if (cur_div) begin
         add_a = {cur_hi[XLEN-2:0], cur_lo[XLEN-1]};
         add_b = ~cur_m;
         add_c = 1'b1;
      end
`endif
      {carry, sum} = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_c};
      hi_nxt = {carry, sum[XLEN-1:1]};
      lo_nxt = {sum[0], cur_lo[XLEN-1:1]};
`ifdef ALU_SEQ_DIV_EN
      if (cur_div) begin
         // The bit shifted out of hi makes the partial remainder >= 2^XLEN,
         // so the subtract always fits even when the adder reports a borrow.
         ge     = carry | cur_hi[XLEN-1];
         hi_nxt = ge ? sum : add_a;
         lo_nxt = {cur_lo[XLEN-2:0], ge};
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q  <= '0;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
         run   <= 1'b0;
         neg_p <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= 1'b0;
         neg_r <= 1'b0;
         bzero <= 1'b0;
         a_q   <= '0;
`endif
      end else if (start) begin
         op_q  <= op;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         mcand <= b_mag;
         cnt   <= CW'(1);
         run   <= 1'b1;
         neg_p <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
         div_q <= cur_div;
         neg_r <= a_neg;
         bzero <= (b == '0);
         a_q   <= a;
`endif
      end else if (run) begin
         if (cnt == LAST) begin
            run <= 1'b0;
         end else begin
            cnt <= cnt + CW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
         end
      end
   end

   assign done = run && (cnt == LAST);

   always_comb begin
      prod = {hi, lo};
      if (neg_p) prod = -prod;
      result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
         if (bzero)
            result = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
         else if ((op_q == OP_DIV) || (op_q == OP_DIVU))
            result = neg_p ? -lo : lo;
         else
            result = neg_r ? -hi : hi;
      end
`endif
   end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit -- sequential ALU with valid/ready handshake.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_seq_unit_if.slave (in_valid/in_ready/in_op/in_a/in_b,
//           out_valid/out_ready/out_result/out_illegal)
//   Single-step ops complete 1 cycle after accept; multiply (and divide when
//   ALU_SEQ_DIV_EN is defined) complete XLEN+1 cycles after accept.
//   Unsupported opcodes return out_illegal=1 with result 0.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OP_W = 5
)
(
   input logic           clk,
   input logic           reset,
   alu_seq_unit_if.slave bus
);
   localparam int unsigned SHW = $clog2(XLEN);

   state_e          state;
   logic            in_ready_q, out_valid_q, out_illegal_q;
   logic [XLEN-1:0] out_result_q, alu_res, iter_result;
   logic [4:0]      op5;
   logic            op_hi;
   op_class_e       cls;
   logic [SHW-1:0]  shamt;
   logic            iter_start, iter_done;

   // Opcodes wider than the 5-bit table are illegal if any upper bit is set.
   always_comb begin
      op5   = 5'(bus.in_op);
      op_hi = (OP_W > 5) && ((bus.in_op >> 5) != '0);
      cls   = op_hi ? CLS_ILLEGAL : op_class(op5);
   end

   always_comb begin
      shamt   = bus.in_b[SHW-1:0];
      alu_res = '0;
      case (op5)
         OP_ADD:  alu_res = bus.in_a + bus.in_b;
         OP_SUB:  alu_res = bus.in_a - bus.in_b;
         OP_AND:  alu_res = bus.in_a & bus.in_b;
         OP_OR:   alu_res = bus.in_a | bus.in_b;
         OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
         OP_SLL:  alu_res = bus.in_a << shamt;
         OP_SRL:  alu_res = bus.in_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(bus.in_a) >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
         default: alu_res = '0;
      endcase
   end

   assign iter_start = (state == ST_IDLE) && bus.in_valid &&
                       ((cls == CLS_MUL) || (cls == CLS_DIV));

   alu_seq_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (iter_start),
      .op     (op5),
      .a      (bus.in_a),
      .b      (bus.in_b),
      .done   (iter_done),
      .result (iter_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
                  if ((cls == CLS_MUL) || (cls == CLS_DIV)) begin
                     state <= ST_BUSY;
                  end else begin
                     state         <= ST_DONE;
                     out_valid_q   <= 1'b1;
                     out_result_q  <= (cls == CLS_ILLEGAL) ? '0 : alu_res;
                     out_illegal_q <= (cls == CLS_ILLEGAL);
                  end
               end
            end
            ST_BUSY: begin
               if (iter_done) begin
                  state         <= ST_DONE;
                  out_valid_q   <= 1'b1;
                  out_result_q  <= iter_result;
                  out_illegal_q <= 1'b0;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_illegal = out_illegal_q;

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter: OP_W, 5, opcode width.
REQ-003 Ports: clk  in  1  rising-edge clock.
REQ-004 Ports: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: in_valid  in  1  request valid.
REQ-006 Ports: in_ready  out  1  unit can accept a request.
REQ-007 Ports: in_op  in  OP_W  operation code (alu_seq_pkg).
REQ-008 Ports: in_a, in_b  in  XLEN  operands.
REQ-009 Ports: out_valid  out  1  result valid.
REQ-010 Ports: out_ready  in  1  consumer accepts result.
REQ-011 Ports: out_result  out  XLEN  result.
REQ-012 Ports: out_illegal  out  1  opcode unsupported; qualified by out_valid.

Function
REQ-013 Ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (single-step), MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (iterative).
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-015 Accept on in_valid&&in_ready; operands and op SHALL be captured that edge; inputs ignored outside IDLE.
REQ-016 Single-step ops: IDLE->DONE; out_valid asserted exactly 1 cycle after accept.
REQ-017 Iterative ops: IDLE->BUSY, XLEN cycles of radix-2 iteration, BUSY->DONE; out_valid asserted XLEN+1 cycles after accept.
REQ-018 Shift amount SHALL be in_b[$clog2(XLEN)-1:0]; SRA sign-fills; SLT signed, SLTU unsigned, result 0/1 zero-extended.
REQ-019 MUL returns low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-020 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = in_a; takes full XLEN+1 latency.
REQ-021 Signed overflow (in_a = most-negative, in_b = -1): DIV returns in_a, REM returns 0.
REQ-022 Signed DIV quotient truncates toward zero; REM sign follows dividend.
REQ-023 out_result, out_illegal SHALL hold stable while out_valid && !out_ready.
REQ-024 DONE->IDLE on out_ready; in_ready rises the following cycle (no same-cycle turnaround).
REQ-025 Undefined opcode: out_illegal=1, out_result=0, single-step latency.

Reset
REQ-026 reset SHALL force state IDLE, in_ready=1 after release, out_valid=0, out_result=0, out_illegal=0, iteration counter 0.
REQ-027 reset asserted mid-BUSY or in DONE SHALL abort the operation; no result is delivered after release.

Configuration
REQ-028 Macro ALU_SEQ_DIV_EN: defined -> DIV/DIVU/REM/REMU implemented per REQ-020..022.
REQ-029 Undefined -> divide datapath absent; those opcodes behave as REQ-025 (out_illegal=1, result 0, latency 1).

Structure
REQ-030 Package alu_seq_pkg SHALL hold opcode constants, op-class decode function, and FSM state encoding.
REQ-031 Sub-module alu_seq_iter SHALL implement shift-add multiply and restoring divide sharing one XLEN-bit adder and counter; top holds FSM, single-step datapath, output register.

Verification
REQ-032 ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid at cycle 1 after accept, result 0x00000000, out_illegal=0.
REQ-033 MULH 0x80000000*0x80000000 -> result 0x40000000 after 33 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-035 out_ready held 0 for 5 cycles after SRA 0x80000000>>4 -> result 0xF8000000 stable all 5 cycles, in_ready=0 throughout.
REQ-036 reset pulsed at BUSY cycle 10 of DIVU -> out_valid never asserts, in_ready=1 first cycle after release.
REQ-037 Build without ALU_SEQ_DIV_EN, issue REM -> out_illegal=1, result 0, 1-cycle latency.
